// File: rtl/datapath_mc.sv
// -----------------------------------------------------------------------------
// datapath_mc
//   Bus-based multi-cycle CPU datapath. One shared combinational bus connects a
//   general register file, PC/IR, MAR/MDR, HI/LO and the Y/Z ALU holding
//   registers. The ALU does single-cycle logic/arithmetic plus an iterative
//   unsigned multiply (shift-add) and divide (restoring), one bit per clock,
//   with a start/busy/done handshake.
//
// Ports
//   clock, clear            rising-edge clock, async active-low reset
//   reg_sel, gpr_in/out     GPR index, write-from-bus / drive-onto-bus
//   pc_in/out/inc           PC load / drive / increment (load wins)
//   ir_in/out, mar_in       IR load / drive, MAR load
//   mdr_in/out/read         MDR load / drive; read=1 sources mem_data_in
//   mem_data_in             memory read data
//   hi_in/out, lo_in/out    HI/LO load / drive
//   y_in                    Y (ALU operand A) load
//   zhi_out, zlo_out        drive upper / lower half of Z
//   alu_op, alu_start       operation code, start pulse
//   alu_busy, alu_done      iterative op in flight, one-cycle completion
//   bus, bus_conflict       bus value, >1 driver enabled
//   mar_q, mdr_q, ir_q      register contents for memory and control
// -----------------------------------------------------------------------------
module datapath_mc #(
    parameter int WIDTH   = 32,
    parameter int NREGS   = 16,
    parameter int ADDR_W  = 4,
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [ADDR_W-1:0] reg_sel,
    input  logic              gpr_in,
    input  logic              gpr_out,
    input  logic              pc_in,
    input  logic              pc_out,
    input  logic              pc_inc,
    input  logic              ir_in,
    input  logic              ir_out,
    input  logic              mar_in,
    input  logic              mdr_in,
    input  logic              mdr_out,
    input  logic              mdr_read,
    input  logic [WIDTH-1:0]  mem_data_in,
    input  logic              hi_in,
    input  logic              hi_out,
    input  logic              lo_in,
    input  logic              lo_out,
    input  logic              y_in,
    input  logic              zhi_out,
    input  logic              zlo_out,
    input  logic [4:0]        alu_op,
    input  logic              alu_start,
    output logic              alu_busy,
    output logic              alu_done,
    output logic [WIDTH-1:0]  bus,
    output logic              bus_conflict,
    output logic [WIDTH-1:0]  mar_q,
    output logic [WIDTH-1:0]  mdr_q,
    output logic [WIDTH-1:0]  ir_q
);

    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_AND = 5'd2;
    localparam logic [4:0] OP_OR  = 5'd3;
    localparam logic [4:0] OP_SHR = 5'd4;
    localparam logic [4:0] OP_SHL = 5'd5;
    localparam logic [4:0] OP_NEG = 5'd6;
    localparam logic [4:0] OP_NOT = 5'd7;
    localparam logic [4:0] OP_MUL = 5'd8;
    localparam logic [4:0] OP_DIV = 5'd9;

    // Iteration counter runs 0..WIDTH-1; the last value marks the final edge.
    localparam int              CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    logic [WIDTH-1:0]   gpr_q [NREGS];
    logic [WIDTH-1:0]   pc_q, hi_q, lo_q, y_q;
    logic [2*WIDTH-1:0] z_q;
    logic [WIDTH-1:0]   gpr_rd;
    logic [7:0]         drv;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   opa_q;   // MUL: multiplicand, DIV: divisor
    logic [WIDTH-1:0]   whi_q;   // MUL: partial product hi, DIV: remainder
    logic [WIDTH-1:0]   wlo_q;   // MUL: multiplier/product lo, DIV: dividend/quotient

    // ---------------------------------------------------------------- bus
    assign gpr_rd = (ZERO_R0 && reg_sel == '0) ? '0 : gpr_q[reg_sel];
    assign drv    = {gpr_out, pc_out, ir_out, mdr_out, hi_out, lo_out, zhi_out, zlo_out};
    // Clearing the lowest set bit leaves something only if two or more are set.
    assign bus_conflict = |(drv & (drv - 8'd1));

    always_comb begin
        bus = '0;
        if (gpr_out)      bus = gpr_rd;
        else if (pc_out)  bus = pc_q;
        else if (ir_out)  bus = ir_q;
        else if (mdr_out) bus = mdr_q;
        else if (hi_out)  bus = hi_q;
        else if (lo_out)  bus = lo_q;
        else if (zhi_out) bus = z_q[2*WIDTH-1:WIDTH];
        else if (zlo_out) bus = z_q[WIDTH-1:0];
    end

    // ---------------------------------------------------------- registers
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < NREGS; i++) gpr_q[i] <= '0;
        end else if (gpr_in && !(ZERO_R0 && reg_sel == '0)) begin
            gpr_q[reg_sel] <= bus;
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            pc_q  <= '0;
            ir_q  <= '0;
            mar_q <= '0;
            mdr_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            y_q   <= '0;
        end else begin
            if (pc_in)       pc_q <= bus;
            else if (pc_inc) pc_q <= pc_q + WIDTH'(1);
            if (ir_in)  ir_q  <= bus;
            if (mar_in) mar_q <= bus;
            if (mdr_in) mdr_q <= mdr_read ? mem_data_in : bus;
            if (hi_in)  hi_q  <= bus;
            if (lo_in)  lo_q  <= bus;
            if (y_in)   y_q   <= bus;
        end
    end

    // ------------------------------------------------- single-cycle ALU
    logic [WIDTH-1:0] single_res;

    always_comb begin
        single_res = '0;
        case (alu_op)
            OP_ADD:  single_res = y_q + bus;
            OP_SUB:  single_res = y_q - bus;
            OP_AND:  single_res = y_q & bus;
            OP_OR:   single_res = y_q | bus;
            OP_SHR:  single_res = y_q >> bus[4:0];
            OP_SHL:  single_res = y_q << bus[4:0];
            OP_NEG:  single_res = '0 - bus;
            OP_NOT:  single_res = ~bus;
            default: single_res = '0;
        endcase
    end

    // ------------------------------------------- iterative step networks
    // Shift-add: add multiplicand into the high half when the current
    // multiplier bit is set, then shift the 2W-bit pair right by one.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_nx, mul_lo_nx;

    assign mul_sum   = {1'b0, whi_q} + {1'b0, (wlo_q[0] ? opa_q : '0)};
    assign mul_hi_nx = mul_sum[WIDTH:1];
    assign mul_lo_nx = {mul_sum[0], wlo_q[WIDTH-1:1]};

    // Restoring divide: shift the next dividend bit into the remainder and
    // keep the subtraction only if it did not borrow. A zero divisor never
    // borrows, which naturally yields all-ones quotient and remainder = A.
    logic [WIDTH:0]   div_sh, div_diff;
    logic [WIDTH-1:0] div_rem_nx, div_quo_nx;

    assign div_sh   = {whi_q, wlo_q[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, opa_q};

    always_comb begin
        if (!div_diff[WIDTH]) begin
            div_rem_nx = div_diff[WIDTH-1:0];
            div_quo_nx = {wlo_q[WIDTH-2:0], 1'b1};
        end else begin
            div_rem_nx = div_sh[WIDTH-1:0];
            div_quo_nx = {wlo_q[WIDTH-2:0], 1'b0};
        end
    end

    // ---------------------------------------------------------- ALU FSM
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q  <= S_IDLE;
            alu_busy <= 1'b0;
            alu_done <= 1'b0;
            cnt_q    <= '0;
            opa_q    <= '0;
            whi_q    <= '0;
            wlo_q    <= '0;
            z_q      <= '0;
        end else begin
            alu_done <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    state_q <= S_IDLE;
                    if (alu_start) begin
                        cnt_q <= '0;
                        whi_q <= '0;
                        if (alu_op == OP_MUL) begin
                            state_q  <= S_MUL;
                            alu_busy <= 1'b1;
                            opa_q    <= y_q;
                            wlo_q    <= bus;
                        end else if (alu_op == OP_DIV) begin
                            state_q  <= S_DIV;
                            alu_busy <= 1'b1;
                            opa_q    <= bus;
                            wlo_q    <= y_q;
                        end else begin
                            state_q  <= S_DONE;
                            alu_done <= 1'b1;
                            z_q      <= {{WIDTH{1'b0}}, single_res};
                        end
                    end
                end
                S_MUL: begin
                    whi_q <= mul_hi_nx;
                    wlo_q <= mul_lo_nx;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) begin
                        z_q      <= {mul_hi_nx, mul_lo_nx};
                        state_q  <= S_DONE;
                        alu_busy <= 1'b0;
                        alu_done <= 1'b1;
                    end
                end
                S_DIV: begin
                    whi_q <= div_rem_nx;
                    wlo_q <= div_quo_nx;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) begin
                        z_q      <= {div_rem_nx, div_quo_nx};
                        state_q  <= S_DONE;
                        alu_busy <= 1'b0;
                        alu_done <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    alu_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_datapath_mc.sv
// -----------------------------------------------------------------------------
// tb_datapath_mc
//   Directed scenarios plus randomized control streams, every cycle compared
//   against a register-level behavioural model of the datapath. Iterative ops
//   are modelled as a countdown that deposits a precomputed * / % result.
// -----------------------------------------------------------------------------
module tb_datapath_mc;

    localparam int W = 32;

    typedef struct packed {
        logic [3:0]  sel;
        logic        gpr_in, gpr_out, pc_in, pc_out, pc_inc, ir_in, ir_out;
        logic        mar_in, mdr_in, mdr_out, mdr_read;
        logic [31:0] mem;
        logic        hi_in, hi_out, lo_in, lo_out, y_in, zhi_out, zlo_out;
        logic [4:0]  op;
        logic        start;
    } ctl_t;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    ctl_t        c = '0;   // applied to the DUT
    ctl_t        n = '0;   // staged by the caller, applied at the next negedge

    logic        alu_busy, alu_done, bus_conflict;
    logic [31:0] bus, mar_q, mdr_q, ir_q;

    int n_vec = 0;
    int n_err = 0;

    // model state
    logic [31:0] m_gpr [16];
    logic [31:0] m_pc, m_ir, m_mar, m_mdr, m_hi, m_lo, m_y;
    logic [63:0] m_z, m_pz;
    int          m_pend;
    bit          m_done;

    bit s_busy, s_done;

    always #5 clock = ~clock;

    datapath_mc #(.WIDTH(32), .NREGS(16), .ADDR_W(4), .ZERO_R0(1'b1)) dut (
        .clock(clock), .clear(clear), .reg_sel(c.sel),
        .gpr_in(c.gpr_in), .gpr_out(c.gpr_out),
        .pc_in(c.pc_in), .pc_out(c.pc_out), .pc_inc(c.pc_inc),
        .ir_in(c.ir_in), .ir_out(c.ir_out), .mar_in(c.mar_in),
        .mdr_in(c.mdr_in), .mdr_out(c.mdr_out), .mdr_read(c.mdr_read),
        .mem_data_in(c.mem),
        .hi_in(c.hi_in), .hi_out(c.hi_out), .lo_in(c.lo_in), .lo_out(c.lo_out),
        .y_in(c.y_in), .zhi_out(c.zhi_out), .zlo_out(c.zlo_out),
        .alu_op(c.op), .alu_start(c.start),
        .alu_busy(alu_busy), .alu_done(alu_done),
        .bus(bus), .bus_conflict(bus_conflict),
        .mar_q(mar_q), .mdr_q(mdr_q), .ir_q(ir_q)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_gpr[i] = '0;
        m_pc = '0; m_ir = '0; m_mar = '0; m_mdr = '0;
        m_hi = '0; m_lo = '0; m_y = '0; m_z = '0; m_pz = '0;
        m_pend = 0; m_done = 1'b0;
    endtask

    function automatic logic [31:0] exp_bus();
        if (c.gpr_out) return (c.sel == 4'd0) ? 32'h0 : m_gpr[c.sel];
        if (c.pc_out)  return m_pc;
        if (c.ir_out)  return m_ir;
        if (c.mdr_out) return m_mdr;
        if (c.hi_out)  return m_hi;
        if (c.lo_out)  return m_lo;
        if (c.zhi_out) return m_z[63:32];
        if (c.zlo_out) return m_z[31:0];
        return 32'h0;
    endfunction

    function automatic bit exp_conflict();
        int k;
        k = int'(c.gpr_out) + int'(c.pc_out) + int'(c.ir_out) + int'(c.mdr_out)
          + int'(c.hi_out) + int'(c.lo_out) + int'(c.zhi_out) + int'(c.zlo_out);
        return k > 1;
    endfunction

    function automatic logic [63:0] alu_ref(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic [63:0] a64, b64;
        a64 = {32'h0, a};
        b64 = {32'h0, b};
        case (op)
            5'd0: r = a + b;
            5'd1: r = a - b;
            5'd2: r = a & b;
            5'd3: r = a | b;
            5'd4: r = a >> b[4:0];
            5'd5: r = a << b[4:0];
            5'd6: r = 32'h0 - b;
            5'd7: r = ~b;
            5'd8: return a64 * b64;
            5'd9: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: r = 32'h0;
        endcase
        return {32'h0, r};
    endfunction

    // One clock: apply staged controls at negedge, check, then advance model.
    task automatic step(input bit xe, input string tag, input logic [31:0] ev);
        logic [31:0] b;
        @(negedge clock);
        c = n;
        #1;
        b = exp_bus();
        s_busy = alu_busy;
        s_done = alu_done;
        chk("bus", {32'h0, bus}, {32'h0, b});
        chk("conflict", {63'h0, bus_conflict}, {63'h0, exp_conflict()});
        chk("busy", {63'h0, alu_busy}, {63'h0, m_pend > 0});
        chk("done", {63'h0, alu_done}, {63'h0, m_done});
        chk("mar", {32'h0, mar_q}, {32'h0, m_mar});
        chk("mdr", {32'h0, mdr_q}, {32'h0, m_mdr});
        chk("ir", {32'h0, ir_q}, {32'h0, m_ir});
        if (xe) chk(tag, {32'h0, bus}, {32'h0, ev});
        @(posedge clock);
        // ALU first: it consumes the old Y
        m_done = 1'b0;
        if (m_pend > 0) begin
            m_pend--;
            if (m_pend == 0) begin
                m_z = m_pz;
                m_done = 1'b1;
            end
        end else if (c.start) begin
            if (c.op == 5'd8 || c.op == 5'd9) begin
                m_pz = alu_ref(c.op, m_y, b);
                m_pend = W;
            end else begin
                m_z = alu_ref(c.op, m_y, b);
                m_done = 1'b1;
            end
        end
        if (c.gpr_in && c.sel != 4'd0) m_gpr[c.sel] = b;
        if (c.pc_in)       m_pc = b;
        else if (c.pc_inc) m_pc = m_pc + 32'd1;
        if (c.ir_in)  m_ir  = b;
        if (c.mar_in) m_mar = b;
        if (c.mdr_in) m_mdr = c.mdr_read ? c.mem : b;
        if (c.hi_in)  m_hi  = b;
        if (c.lo_in)  m_lo  = b;
        if (c.y_in)   m_y   = b;
    endtask

    task automatic tick();
        step(1'b0, "", 32'h0);
    endtask

    task automatic load_mdr(input logic [31:0] v);
        n = '0; n.mdr_in = 1'b1; n.mdr_read = 1'b1; n.mem = v;
        tick();
    endtask

    task automatic set_y(input logic [31:0] v);
        load_mdr(v);
        n = '0; n.mdr_out = 1'b1; n.y_in = 1'b1;
        tick();
    endtask

    function automatic logic [31:0] rv();
        case ($urandom_range(0, 4))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    int busy_cnt, done_cnt;

    initial begin
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        clear = 1'b1;

        // reset state: nothing driven, all zero
        n = '0; tick();
        n = '0; n.zlo_out = 1'b1; step(1'b1, "rst_zlo", 32'h0);
        n = '0; n.pc_out = 1'b1;  step(1'b1, "rst_pc", 32'h0);

        // ADD 7 + 5 through R3
        set_y(32'd7);
        load_mdr(32'd5);
        n = '0; n.mdr_out = 1'b1; n.gpr_in = 1'b1; n.sel = 4'd3; tick();
        n = '0; n.gpr_out = 1'b1; n.sel = 4'd3; n.start = 1'b1; n.op = 5'd0;
        step(1'b1, "r3_read", 32'd5);
        chk("add_busy", {63'h0, s_busy}, 64'h0);
        n = '0; n.zlo_out = 1'b1; step(1'b1, "add_zlo", 32'd12);
        chk("add_done", {63'h0, s_done}, 64'h1);
        chk("add_busy2", {63'h0, s_busy}, 64'h0);
        n = '0; n.zhi_out = 1'b1; step(1'b1, "add_zhi", 32'd0);
        chk("add_done_off", {63'h0, s_done}, 64'h0);

        // MUL all-ones, with an ignored second start mid-flight
        set_y(32'hFFFF_FFFF);
        n = '0; n.mdr_out = 1'b1; n.start = 1'b1; n.op = 5'd8; tick();
        busy_cnt = 0; done_cnt = 0;
        for (int i = 0; i < W + 1; i++) begin
            n = '0;
            if (i == 10) begin n.mdr_out = 1'b1; n.start = 1'b1; n.op = 5'd0; end
            tick();
            busy_cnt += int'(s_busy);
            done_cnt += int'(s_done);
        end
        chk("mul_busy_cycles", 64'(busy_cnt), 64'd32);
        chk("mul_done_pulses", 64'(done_cnt), 64'd1);
        n = '0; n.zhi_out = 1'b1; step(1'b1, "mul_zhi", 32'hFFFF_FFFE);
        n = '0; n.zlo_out = 1'b1; step(1'b1, "mul_zlo", 32'h0000_0001);

        // DIV 100 / 7
        set_y(32'd100);
        load_mdr(32'd7);
        n = '0; n.mdr_out = 1'b1; n.start = 1'b1; n.op = 5'd9; tick();
        for (int i = 0; i < W + 1; i++) begin n = '0; tick(); end
        n = '0; n.zlo_out = 1'b1; step(1'b1, "div_quo", 32'd14);
        n = '0; n.zhi_out = 1'b1; step(1'b1, "div_rem", 32'd2);

        // DIV 9 / 0 (undriven bus gives B = 0)
        set_y(32'd9);
        n = '0; n.start = 1'b1; n.op = 5'd9; tick();
        for (int i = 0; i < W + 1; i++) begin n = '0; tick(); end
        n = '0; n.zlo_out = 1'b1; step(1'b1, "div0_quo", 32'hFFFF_FFFF);
        n = '0; n.zhi_out = 1'b1; step(1'b1, "div0_rem", 32'd9);

        // R0 hardwired to zero
        load_mdr(32'hAB);
        n = '0; n.mdr_out = 1'b1; n.gpr_in = 1'b1; n.sel = 4'd0; tick();
        n = '0; n.gpr_out = 1'b1; n.sel = 4'd0; step(1'b1, "r0_read", 32'h0);

        // PC wrap, pc_in over pc_inc, conflict priority
        load_mdr(32'hFFFF_FFFF);
        n = '0; n.mdr_out = 1'b1; n.pc_in = 1'b1; tick();
        n = '0; n.pc_inc = 1'b1; tick();
        n = '0; n.pc_out = 1'b1; step(1'b1, "pc_wrap", 32'h0);
        load_mdr(32'h40);
        n = '0; n.mdr_out = 1'b1; n.pc_in = 1'b1; n.pc_inc = 1'b1; tick();
        n = '0; n.pc_out = 1'b1; n.mdr_out = 1'b1; step(1'b1, "pc_load", 32'h40);
        chk("conflict_pc_mdr", {63'h0, bus_conflict}, 64'h1);

        // MDR takes memory data, not the bus, when mdr_read=1
        n = '0; n.pc_out = 1'b1; n.mdr_in = 1'b1; n.mdr_read = 1'b1; n.mem = 32'h1234_5678; tick();
        n = '0; n.mdr_out = 1'b1; n.mar_in = 1'b1; n.ir_in = 1'b1;
        step(1'b1, "mdr_mem", 32'h1234_5678);

        // Reset in the middle of a MUL
        set_y(32'd3);
        load_mdr(32'd5);
        n = '0; n.mdr_out = 1'b1; n.start = 1'b1; n.op = 5'd8; tick();
        for (int i = 0; i < 4; i++) begin n = '0; tick(); end
        @(negedge clock);
        c = '0; c.zlo_out = 1'b1; n = c;
        #1 clear = 1'b0;
        #1;
        chk("rr_busy", {63'h0, alu_busy}, 64'h0);
        chk("rr_done", {63'h0, alu_done}, 64'h0);
        chk("rr_zlo", {32'h0, bus}, 64'h0);
        chk("rr_mar", {32'h0, mar_q}, 64'h0);
        chk("rr_mdr", {32'h0, mdr_q}, 64'h0);
        chk("rr_ir", {32'h0, ir_q}, 64'h0);
        model_reset();
        @(negedge clock);
        #2 clear = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < W + 4; i++) begin
            n = '0; n.zlo_out = 1'b1;
            tick();
            done_cnt += int'(s_done);
        end
        chk("rr_no_done", 64'(done_cnt), 64'd0);

        // Randomized control streams
        for (int i = 0; i < 2500; i++) begin
            logic [7:0] o;
            n = '0;
            case ($urandom_range(0, 9))
                8: o = 8'h0;
                9: o = (8'h1 << $urandom_range(0, 7)) | (8'h1 << $urandom_range(0, 7));
                default: o = 8'h1 << $urandom_range(0, 7);
            endcase
            {n.gpr_out, n.pc_out, n.ir_out, n.mdr_out, n.hi_out, n.lo_out, n.zhi_out, n.zlo_out} = o;
            n.sel      = 4'($urandom_range(0, 15));
            n.gpr_in   = ($urandom_range(0, 3) == 0);
            n.pc_in    = ($urandom_range(0, 5) == 0);
            n.pc_inc   = ($urandom_range(0, 5) == 0);
            n.ir_in    = ($urandom_range(0, 5) == 0);
            n.mar_in   = ($urandom_range(0, 5) == 0);
            n.mdr_in   = ($urandom_range(0, 2) == 0);
            n.mdr_read = ($urandom_range(0, 1) == 0);
            n.mem      = rv();
            n.hi_in    = ($urandom_range(0, 5) == 0);
            n.lo_in    = ($urandom_range(0, 5) == 0);
            n.y_in     = ($urandom_range(0, 3) == 0);
            n.start    = ($urandom_range(0, 5) == 0);
            n.op       = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(10, 31)) : 5'($urandom_range(0, 9));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
